// File: rtl/fxp_mux_pkg.sv
// Shared types and constants for the fixed-point mux arbiter and its helpers.
// Samples are opaque signed Qm.n words; nothing here does arithmetic on them.
package fxp_mux_pkg;

    localparam int DEF_N  = 4;
    localparam int DEF_W  = 16;
    localparam int DEF_BP = 8;

    function automatic int clog2(input int v);
        int r;
        for (r = 0; (1 << r) < v; r++) begin
        end
        return r;
    endfunction

    typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_e;

    typedef struct packed {
        logic [DEF_W-1:0] data;
        logic             last;
    } beat_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first asserted request at or after ptr_i,
// wrapping modulo N. Returns the pick as one-hot and as an index.
module rr_picker #(
    parameter int N    = 4,
    parameter int IDXW = 2
) (
    input  logic [N-1:0]    req_i,
    input  logic [IDXW-1:0] ptr_i,
    output logic [N-1:0]    grant_o,
    output logic [IDXW-1:0] idx_o,
    output logic            valid_o
);

    int              c;
    logic [IDXW-1:0] ci;

    always_comb begin
        c       = 0;
        ci      = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        for (int k = 0; k < N; k++) begin
            // ptr_i is always < N, so a single subtract is enough to wrap
            c = int'(ptr_i) + k;
            if (c >= N) c = c - N;
            ci = IDXW'(c);
            if (!valid_o && req_i[ci]) begin
                valid_o = 1'b1;
                idx_o   = ci;
            end
        end
        grant_o = valid_o ? (N'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/fixed_point_mux_arbiter.sv
// Round-robin N:1 mux for fixed-point sample streams with packet lock and a
// single registered output stage. Samples pass through bit-exact.
module fixed_point_mux_arbiter
    import fxp_mux_pkg::*;
#(
    parameter int N    = DEF_N,
    parameter int W    = DEF_W,
    parameter int BP   = DEF_BP,
    parameter int IDXW = clog2(DEF_N)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    input  logic [N*W-1:0]  in_bits,
    input  logic [N-1:0]    in_last,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    out_bits,
    output logic            out_last,
    output logic [IDXW-1:0] out_idx,
    output logic            busy
);

    if (IDXW != clog2(N) || N < 2 || BP < 0 || BP > W) begin : g_bad_cfg
        $error("fixed_point_mux_arbiter: inconsistent N/IDXW/BP/W");
    end

    state_e          state_q;
    logic [IDXW-1:0] grant_q, rr_ptr_q;
    logic            out_valid_q, out_last_q;
    logic [W-1:0]    out_bits_q;
    logic [IDXW-1:0] out_idx_q;

    logic [N-1:0][W-1:0] bits_v;
    logic [N-1:0]        pick_oh;
    logic [IDXW-1:0]     pick_idx, sel;
    logic                pick_vld, slot_free, xfer;

    assign bits_v = in_bits;

    rr_picker #(.N(N), .IDXW(IDXW)) u_pick (
        .req_i   (in_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (pick_oh),
        .idx_o   (pick_idx),
        .valid_o (pick_vld)
    );

    function automatic logic [IDXW-1:0] wrap_inc(input logic [IDXW-1:0] x);
        return (int'(x) == N - 1) ? '0 : x + 1'b1;
    endfunction

    assign slot_free = !out_valid_q || out_ready;
    assign sel       = (state_q == LOCK) ? grant_q : pick_idx;

    always_comb begin
        in_ready = '0;
        if (state_q == LOCK) in_ready[grant_q] = slot_free;
        else if (pick_vld)   in_ready = pick_oh & {N{slot_free}};
    end

    assign xfer = |(in_valid & in_ready);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_bits_q  <= '0;
            out_last_q  <= 1'b0;
            out_idx_q   <= '0;
        end else begin
            if (xfer) begin
                out_valid_q <= 1'b1;
                out_bits_q  <= bits_v[sel];
                out_last_q  <= in_last[sel];
                out_idx_q   <= sel;
                // a packet's last beat always releases the mux and advances fairness
                if (in_last[sel]) begin
                    state_q  <= IDLE;
                    rr_ptr_q <= wrap_inc(sel);
                end else if (state_q == IDLE) begin
                    state_q <= LOCK;
                    grant_q <= sel;
                end
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_bits  = out_bits_q;
    assign out_last  = out_last_q;
    assign out_idx   = out_idx_q;
    assign busy      = (state_q == LOCK);

endmodule

// File: tb/tb_fixed_point_mux_arbiter.sv
// Directed bench for fixed_point_mux_arbiter: a 4-requester instance for the
// main scenarios and a 3-requester instance for non-power-of-2 wrap.
module tb_fixed_point_mux_arbiter;

    localparam int N = 4, W = 16, BP = 8, IDXW = 2;
    localparam int N3 = 3;

    logic            clock = 1'b0;
    logic            reset;
    logic [N-1:0]    in_valid, in_ready, in_last;
    logic [N*W-1:0]  in_bits;
    logic            out_valid, out_ready, out_last, busy;
    logic [W-1:0]    out_bits;
    logic [IDXW-1:0] out_idx;

    logic [N3-1:0]   w_in_valid, w_in_ready, w_in_last;
    logic [N3*W-1:0] w_in_bits;
    logic            w_out_valid, w_out_ready, w_out_last, w_busy;
    logic [W-1:0]    w_out_bits;
    logic [IDXW-1:0] w_out_idx;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    fixed_point_mux_arbiter #(.N(N), .W(W), .BP(BP), .IDXW(IDXW)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_bits(in_bits), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_bits(out_bits),
        .out_last(out_last), .out_idx(out_idx), .busy(busy)
    );

    fixed_point_mux_arbiter #(.N(N3), .W(W), .BP(BP), .IDXW(IDXW)) dut3 (
        .clock(clock), .reset(reset),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .in_bits(w_in_bits), .in_last(w_in_last),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_bits(w_out_bits),
        .out_last(w_out_last), .out_idx(w_out_idx), .busy(w_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [W-1:0] d, input logic l);
        in_valid[i]      = v;
        in_bits[i*W +: W] = d;
        in_last[i]       = l;
    endtask

    task automatic set_w(input int i, input logic v, input logic [W-1:0] d, input logic l);
        w_in_valid[i]       = v;
        w_in_bits[i*W +: W] = d;
        w_in_last[i]        = l;
    endtask

    // advance one cycle and land just after the rising edge
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [W-1:0] d,
                           input logic l, input logic [IDXW-1:0] idx);
        chk({tag, "_valid"}, 32'(out_valid), 32'(v));
        chk({tag, "_bits"},  32'(out_bits),  32'(d));
        chk({tag, "_last"},  32'(out_last),  32'(l));
        chk({tag, "_idx"},   32'(out_idx),   32'(idx));
    endtask

    initial begin
        reset = 1'b1;
        in_valid = '0; in_last = '0; in_bits = '0; out_ready = 1'b1;
        w_in_valid = '0; w_in_last = '0; w_in_bits = '0; w_out_ready = 1'b1;
        #1;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_idx",   32'(out_idx),   0);
        chk("rst_busy",  32'(busy),      0);
        chk("rst_ready", 32'(in_ready),  0);
        step(); step();
        reset = 1'b0;

        // fairness: all valid, single-beat packets
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 16'h1000 + 16'(i), 1'b1);
        #1 chk("fair_ready0", 32'(in_ready), 32'h1);
        for (int k = 0; k < 6; k++) begin
            step();
            chk_out($sformatf("fair%0d", k), 1'b1, 16'h1000 + 16'(k % 4), 1'b1, IDXW'(k % 4));
        end
        in_valid = '0;
        step();
        chk("drain_valid", 32'(out_valid), 0);

        // rr now at 2; one req0 beat moves it to 1
        set_req(0, 1'b1, 16'h0055, 1'b1);
        step();
        chk_out("r0", 1'b1, 16'h0055, 1'b1, 2'd0);
        set_req(0, 1'b0, 16'h0000, 1'b0);

        // lock: req1 three-beat packet while req2 waits
        set_req(1, 1'b1, 16'h0180, 1'b0);
        set_req(2, 1'b1, 16'h0AAA, 1'b1);
        #1 chk("lock_ready0", 32'(in_ready), 32'h2);
        step();
        chk_out("lock_b0", 1'b1, 16'h0180, 1'b0, 2'd1);
        chk("lock_busy0", 32'(busy), 1);
        set_req(1, 1'b1, 16'h0200, 1'b0);
        #1 chk("lock_ready1", 32'(in_ready), 32'h2);
        step();
        chk_out("lock_b1", 1'b1, 16'h0200, 1'b0, 2'd1);
        set_req(1, 1'b1, 16'hFE80, 1'b1);
        #1 chk("lock_ready2", 32'(in_ready), 32'h2);
        step();
        chk_out("lock_b2", 1'b1, 16'hFE80, 1'b1, 2'd1);
        chk("lock_busy2", 32'(busy), 0);
        set_req(1, 1'b0, 16'h0000, 1'b0);
        #1 chk("lock_ready3", 32'(in_ready), 32'h4);
        step();
        chk_out("lock_r2", 1'b1, 16'h0AAA, 1'b1, 2'd2);
        set_req(2, 1'b0, 16'h0000, 1'b0);

        // backpressure with output full of the req2 beat; rr at 3
        out_ready = 1'b0;
        set_req(3, 1'b1, 16'h3333, 1'b1);
        set_req(0, 1'b1, 16'h0444, 1'b1);
        for (int k = 0; k < 5; k++) begin
            #1 chk($sformatf("bp_ready%0d", k), 32'(in_ready), 0);
            step();
            chk_out($sformatf("bp_hold%0d", k), 1'b1, 16'h0AAA, 1'b1, 2'd2);
        end
        out_ready = 1'b1;
        #1 chk("bp_release_ready", 32'(in_ready), 32'h8);
        step();
        chk_out("bp_r3", 1'b1, 16'h3333, 1'b1, 2'd3);
        set_req(3, 1'b0, 16'h0000, 1'b0);
        #1 chk("bp_ready_r0", 32'(in_ready), 32'h1);
        step();
        chk_out("bp_r0", 1'b1, 16'h0444, 1'b1, 2'd0);
        set_req(0, 1'b0, 16'h0000, 1'b0);
        step();
        chk("bp_drain", 32'(out_valid), 0);

        // lock stall: rr at 1, req3 wins over req0 then stalls mid-packet
        set_req(3, 1'b1, 16'h7FFF, 1'b0);
        set_req(0, 1'b1, 16'h0001, 1'b1);
        step();
        chk_out("stall_b0", 1'b1, 16'h7FFF, 1'b0, 2'd3);
        set_req(3, 1'b0, 16'h0000, 1'b0);
        for (int k = 0; k < 4; k++) begin
            #1 chk($sformatf("stall_rdy0_%0d", k), 32'(in_ready[0]), 0);
            step();
            chk($sformatf("stall_busy%0d", k), 32'(busy), 1);
            chk($sformatf("stall_oval%0d", k), 32'(out_valid), 0);
        end
        set_req(3, 1'b1, 16'h8000, 1'b1);
        step();
        chk_out("stall_b1", 1'b1, 16'h8000, 1'b1, 2'd3);
        chk("stall_busy_end", 32'(busy), 0);
        set_req(3, 1'b0, 16'h0000, 1'b0);
        step();
        chk_out("stall_r0", 1'b1, 16'h0001, 1'b1, 2'd0);
        set_req(0, 1'b0, 16'h0000, 1'b0);

        // reset mid-packet: req2 locks (rr at 1), then async reset
        set_req(2, 1'b1, 16'h1234, 1'b0);
        step();
        chk_out("mid_b0", 1'b1, 16'h1234, 1'b0, 2'd2);
        chk("mid_busy", 32'(busy), 1);
        set_req(0, 1'b1, 16'h0077, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_idx",   32'(out_idx),   0);
        chk("arst_busy",  32'(busy),      0);
        chk("arst_bits",  32'(out_bits),  0);
        step();
        reset = 1'b0;
        step();
        chk_out("post_rst", 1'b1, 16'h0077, 1'b1, 2'd0);
        in_valid = '0;

        // wrap on the 3-requester build: walk rr to 2 first
        set_w(0, 1'b1, 16'h00A0, 1'b1);
        step();
        chk("w_b0_idx", 32'(w_out_idx), 0);
        set_w(0, 1'b0, 16'h0000, 1'b0);
        set_w(1, 1'b1, 16'h00A1, 1'b1);
        step();
        chk("w_b1_idx", 32'(w_out_idx), 1);
        set_w(1, 1'b0, 16'h0000, 1'b0);
        set_w(0, 1'b1, 16'h00B0, 1'b1);
        set_w(2, 1'b1, 16'h00B2, 1'b1);
        #1 chk("w_ready2", 32'(w_in_ready), 32'h4);
        step();
        chk("w_r2_idx",  32'(w_out_idx),  2);
        chk("w_r2_bits", 32'(w_out_bits), 32'h00B2);
        set_w(2, 1'b0, 16'h0000, 1'b0);
        #1 chk("w_ready0", 32'(w_in_ready), 32'h1);
        step();
        chk("w_r0_idx",  32'(w_out_idx),  0);
        chk("w_r0_bits", 32'(w_out_bits), 32'h00B0);
        chk("w_r0_val",  32'(w_out_valid), 1);
        w_in_valid = '0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
